retire_trace_encoder: RTL and testbench

Hardware retirement-trace source for the single-cycle CPU. Each cycle it samples the commit-side signals (PC, instruction, register write, memory read/write, halt), classifies the commit, stamps an instruction number, buffers the record in a small FIFO, and serializes it as 16-bit words over a valid/ready stream. The stream is the on-chip producer of the trace that the simulation bench otherwise writes to file; off-chip or debug logic consumes it.

---
 rtl/trace_pkg.sv | 49 ++++
 rtl/trace_fifo.sv | 54 +++++
 rtl/retire_trace_encoder.sv | 192 +++++++++++++++++++
 tb/tb_retire_trace_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retirement trace encoder: record layout, type codes,
// per-type word counts and serializer states.
package trace_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RD_W   = 4;

    typedef enum logic [2:0] {
        T_NOP   = 3'd0,
        T_REG   = 3'd1,
        T_LOAD  = 3'd2,
        T_STORE = 3'd3,
        T_HALT  = 3'd4
    } rec_type_e;

    typedef struct packed {
        rec_type_e         rtype;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] inum;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
    } trace_rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_INUM,
        S_PC,
        S_D0,
        S_D1,
        S_DONE
    } ser_state_e;

    function automatic logic [2:0] rec_len(input rec_type_e t);
        case (t)
            T_REG:   rec_len = 3'd4;
            T_LOAD:  rec_len = 3'd5;
            T_STORE: rec_len = 3'd5;
            T_HALT:  rec_len = 3'd4;
            default: rec_len = 3'd3;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] hdr_word(input trace_rec_t r);
        hdr_word = {r.rtype, r.rd, 9'b0};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of whole trace records with show-ahead head output.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  trace_rec_t i_rec,
    input  logic       i_pop,
    output trace_rec_t o_head_c,
    output logic       o_full_c,
    output logic       o_empty_c
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    trace_rec_t       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_count == CW'(FIFO_DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_push    = i_push & ~o_full_c;
    assign w_pop     = i_pop & ~o_empty_c;
    assign o_head_c  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_rec;
    end

endmodule

// File: rtl/retire_trace_encoder.sv
// Commit classifier, instruction/cycle stamping and 16-bit word serializer
// feeding a valid/ready trace stream.
module retire_trace_encoder
    import trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit_valid,
    input  logic [15:0] pc,
    input  logic        regw,
    input  logic [3:0]  rd,
    input  logic [15:0] dst_data,
    input  logic        memr,
    input  logic        memw,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        hlt,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        overflow,
    output logic        trace_done
);

    logic [15:0] r_inum;
    logic [15:0] r_cyc;
    logic        r_overflow;
    logic        r_halted;
    ser_state_e  r_state;
    trace_rec_t  r_rec;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic        r_out_last;
    logic        r_trace_done;

    trace_rec_t  w_rec;
    trace_rec_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_take;
    logic        w_push;
    logic        w_pop;
    logic        w_fire;
    logic        w_rec_end;
    ser_state_e  w_nxt_state;
    logic        w_nxt_valid;
    logic [15:0] w_nxt_data;
    logic        w_nxt_last;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign overflow   = r_overflow;
    assign trace_done = r_trace_done;

    // Once the halt record is queued the commit stream is closed.
    assign w_take = commit_valid & ~r_halted;
    assign w_push = w_take & ~w_full;
    assign w_fire = r_out_valid & out_ready;

    // Commit classification, priority LOAD > REG > HALT > STORE > NOP.
    always_comb begin
        w_rec      = '0;
        w_rec.inum = r_inum;
        w_rec.pc   = pc;
        if (regw && memr) begin
            w_rec.rtype = T_LOAD;
            w_rec.rd    = rd;
            w_rec.d0    = dst_data;
            w_rec.d1    = mem_addr;
        end else if (regw) begin
            w_rec.rtype = T_REG;
            w_rec.rd    = rd;
            w_rec.d0    = dst_data;
        end else if (hlt) begin
            w_rec.rtype = T_HALT;
            w_rec.d0    = r_cyc;
        end else if (memw) begin
            w_rec.rtype = T_STORE;
            w_rec.d0    = mem_addr;
            w_rec.d1    = mem_wdata;
        end
    end

    trace_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_rec     (w_rec),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // Serializer: each state presents one word; record end chains straight
    // into the next queued record so back-to-back records have no bubble.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_valid = r_out_valid;
        w_nxt_data  = r_out_data;
        w_nxt_last  = r_out_last;
        w_pop       = 1'b0;
        w_rec_end   = 1'b0;
        case (r_state)
            S_IDLE: w_rec_end = 1'b1;
            S_HDR: if (w_fire) begin
                w_nxt_state = S_INUM;
                w_nxt_data  = r_rec.inum;
            end
            S_INUM: if (w_fire) begin
                w_nxt_state = S_PC;
                w_nxt_data  = r_rec.pc;
                w_nxt_last  = (rec_len(r_rec.rtype) == 3'd3);
            end
            S_PC: if (w_fire) begin
                if (r_out_last) begin
                    w_rec_end = 1'b1;
                end else begin
                    w_nxt_state = S_D0;
                    w_nxt_data  = r_rec.d0;
                    w_nxt_last  = (rec_len(r_rec.rtype) == 3'd4);
                end
            end
            S_D0: if (w_fire) begin
                if (r_out_last) begin
                    w_rec_end = 1'b1;
                end else begin
                    w_nxt_state = S_D1;
                    w_nxt_data  = r_rec.d1;
                    w_nxt_last  = 1'b1;
                end
            end
            S_D1: if (w_fire) w_rec_end = 1'b1;
            S_DONE: begin
                w_nxt_valid = 1'b0;
                w_nxt_last  = 1'b0;
            end
            default: w_nxt_state = S_IDLE;
        endcase
        if (w_rec_end) begin
            w_nxt_state = S_IDLE;
            w_nxt_valid = 1'b0;
            w_nxt_data  = '0;
            w_nxt_last  = 1'b0;
            if (r_state != S_IDLE && r_rec.rtype == T_HALT) begin
                w_nxt_state = S_DONE;
            end else if (!w_empty) begin
                w_pop       = 1'b1;
                w_nxt_state = S_HDR;
                w_nxt_valid = 1'b1;
                w_nxt_data  = hdr_word(w_head);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_trace_done <= 1'b0;
            r_rec        <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_out_valid  <= w_nxt_valid;
            r_out_data   <= w_nxt_data;
            r_out_last   <= w_nxt_last;
            r_trace_done <= (w_nxt_state == S_DONE);
            if (w_pop) r_rec <= w_head;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inum     <= '0;
            r_cyc      <= '0;
            r_overflow <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_cyc <= r_cyc + 16'd1;
            if (w_take) r_inum <= r_inum + 16'd1;
            if (w_take && w_full) r_overflow <= 1'b1;
            if (w_push && w_rec.rtype == T_HALT) r_halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_retire_trace_encoder.sv
// Directed bench for retire_trace_encoder: record formats, stalls, overflow,
// halt completion and mid-record reset.
module tb_retire_trace_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid;
    logic [15:0] pc;
    logic        regw;
    logic [3:0]  rd;
    logic [15:0] dst_data;
    logic        memr;
    logic        memw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        hlt;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        overflow;
    logic        trace_done;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [15:0] tb_cyc;
    logic [15:0] exp_w [5];
    int          idx;

    retire_trace_encoder #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .commit_valid (commit_valid),
        .pc           (pc),
        .regw         (regw),
        .rd           (rd),
        .dst_data     (dst_data),
        .memr         (memr),
        .memw         (memw),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .hlt          (hlt),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .trace_done   (trace_done)
    );

    always #5 clk = ~clk;

    // Reference cycle count: zero under reset, +1 per clock otherwise.
    always @(posedge clk) tb_cyc <= rst_n ? tb_cyc + 16'd1 : 16'd0;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        commit_valid = 1'b0; pc = '0; regw = 1'b0; rd = '0; dst_data = '0;
        memr = 1'b0; memw = 1'b0; mem_addr = '0; mem_wdata = '0; hlt = 1'b0;
    endtask

    task automatic drive(input logic i_rw, input logic i_mr, input logic i_mw, input logic i_h,
                         input logic [15:0] i_pc, input logic [3:0] i_rd, input logic [15:0] i_dd,
                         input logic [15:0] i_ma, input logic [15:0] i_md);
        commit_valid = 1'b1; regw = i_rw; memr = i_mr; memw = i_mw; hlt = i_h;
        pc = i_pc; rd = i_rd; dst_data = i_dd; mem_addr = i_ma; mem_wdata = i_md;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_in();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Expects a valid word now (or within maxwait cycles), then lets it be taken.
    task automatic get_word(input string tag, input logic [15:0] exp, input logic exp_last,
                            input int maxwait);
        int n = 0;
        while (out_valid !== 1'b1 && n < maxwait) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, 16'(out_valid), 16'd1);
        chk({tag, ".data"}, out_data, exp);
        chk({tag, ".last"}, 16'(out_last), 16'(exp_last));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        clear_in();
        do_reset();

        chk("rst.valid", 16'(out_valid), 16'd0);
        chk("rst.data", out_data, 16'h0000);
        chk("rst.last", 16'(out_last), 16'd0);
        chk("rst.overflow", 16'(overflow), 16'd0);
        chk("rst.done", 16'(trace_done), 16'd0);

        // REG record, one-cycle latency to w0
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 4'd3, 16'h1234, 16'h0000, 16'h0000);
        @(negedge clk);
        clear_in();
        chk("reg.latency", 16'(out_valid), 16'd0);
        @(negedge clk);
        get_word("reg.w0", 16'h2600, 1'b0, 0);
        get_word("reg.w1", 16'h0000, 1'b0, 0);
        get_word("reg.w2", 16'h0004, 1'b0, 0);
        get_word("reg.w3", 16'h1234, 1'b1, 0);
        chk("reg.idle", 16'(out_valid), 16'd0);

        // LOAD then STORE back-to-back; STORE rd must be zeroed
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 4'd5, 16'hBEEF, 16'h0100, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 4'd7, 16'h9999, 16'h0200, 16'h00AA);
        @(negedge clk);
        clear_in();
        get_word("ld.w0", 16'h4A00, 1'b0, 0);
        get_word("ld.w1", 16'h0000, 1'b0, 0);
        get_word("ld.w2", 16'h0010, 1'b0, 0);
        get_word("ld.w3", 16'hBEEF, 1'b0, 0);
        get_word("ld.w4", 16'h0100, 1'b1, 0);
        get_word("st.w0", 16'h6000, 1'b0, 0);
        get_word("st.w1", 16'h0001, 1'b0, 0);
        get_word("st.w2", 16'h0012, 1'b0, 0);
        get_word("st.w3", 16'h0200, 1'b0, 0);
        get_word("st.w4", 16'h00AA, 1'b1, 0);
        chk("st.idle", 16'(out_valid), 16'd0);

        // 5-word STORE with out_ready toggling every cycle
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 4'd0, 16'h0000, 16'h0300, 16'h0055);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        exp_w[0] = 16'h6000; exp_w[1] = 16'h0002; exp_w[2] = 16'h0020;
        exp_w[3] = 16'h0300; exp_w[4] = 16'h0055;
        idx = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            chk($sformatf("stall.valid%0d", idx), 16'(out_valid), 16'd1);
            chk($sformatf("stall.data%0d", idx), out_data, exp_w[idx]);
            chk($sformatf("stall.last%0d", idx), 16'(out_last), (idx == 4) ? 16'd1 : 16'd0);
            out_ready = ~out_ready;
            if (out_ready) idx++;
            @(negedge clk);
        end
        chk("stall.count", 16'(idx), 16'd5);
        chk("stall.idle", 16'(out_valid), 16'd0);

        // Overflow: six NOPs while stalled; serializer holds one, FIFO four
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0040 + 16'(i), 4'd0, 16'h0, 16'h0, 16'h0);
            @(negedge clk);
        end
        clear_in();
        chk("ovf.flag", 16'(overflow), 16'd1);
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            get_word($sformatf("ovf.r%0d.w0", r), 16'h0000, 1'b0, 0);
            get_word($sformatf("ovf.r%0d.w1", r), 16'(r), 1'b0, 0);
            get_word($sformatf("ovf.r%0d.w2", r), 16'h0040 + 16'(r), 1'b1, 0);
        end
        chk("ovf.drained", 16'(out_valid), 16'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0060, 4'd0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        get_word("ovf.next.w0", 16'h0000, 1'b0, 0);
        get_word("ovf.next.w1", 16'h0006, 1'b0, 0);
        get_word("ovf.next.w2", 16'h0060, 1'b1, 0);
        chk("ovf.sticky", 16'(overflow), 16'd1);

        // HALT at cyc 0x0010; a following commit must be ignored
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 64 && tb_cyc != 16'h0010; c++) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0050, 4'd9, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0052, 4'd1, 16'hFFFF, 16'h0, 16'h0);
        @(negedge clk);
        clear_in();
        get_word("hlt.w0", 16'h8000, 1'b0, 0);
        get_word("hlt.w1", 16'h0000, 1'b0, 0);
        get_word("hlt.w2", 16'h0050, 1'b0, 0);
        chk("hlt.notdone", 16'(trace_done), 16'd0);
        get_word("hlt.w3", 16'h0010, 1'b1, 0);
        chk("hlt.done", 16'(trace_done), 16'd1);
        chk("hlt.novalid", 16'(out_valid), 16'd0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(c), 4'd2, 16'h5555, 16'h0, 16'h0);
            @(negedge clk);
            chk($sformatf("hlt.after%0d.valid", c), 16'(out_valid), 16'd0);
            chk($sformatf("hlt.after%0d.done", c), 16'(trace_done), 16'd1);
        end
        clear_in();

        // Reset during w2 of a LOAD aborts; fresh commit restarts at inum 0
        do_reset();
        chk("rstm.done_clr", 16'(trace_done), 16'd0);
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0070, 4'd2, 16'h1111, 16'h2222, 16'h0);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        get_word("rstm.w0", 16'h4400, 1'b0, 0);
        get_word("rstm.w1", 16'h0000, 1'b0, 0);
        chk("rstm.w2", out_data, 16'h0070);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstm.valid", 16'(out_valid), 16'd0);
        chk("rstm.data", out_data, 16'h0000);
        chk("rstm.last", 16'(out_last), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstm.overflow", 16'(overflow), 16'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 4'd1, 16'h0042, 16'h0, 16'h0);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        get_word("rstm.n.w0", 16'h2200, 1'b0, 0);
        get_word("rstm.n.w1", 16'h0000, 1'b0, 0);
        get_word("rstm.n.w2", 16'h0080, 1'b0, 0);
        get_word("rstm.n.w3", 16'h0042, 1'b1, 0);
        chk("rstm.n.idle", 16'(out_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
